// File: rtl/cfu_bridge_pkg.sv
// cfu_bridge_pkg: Cfu function codes, the data returned for locally completed commands,
// and field extractors for the 10-bit {funct7,funct3} function_id.
package cfu_bridge_pkg;
    typedef enum logic [2:0] {
        FUNCT3_SUM   = 3'd0,
        FUNCT3_SWAP  = 3'd1,
        FUNCT3_REV   = 3'd2,
        FUNCT3_STORE = 3'd3,
        FUNCT3_LOAD  = 3'd4
    } funct3_e;

    localparam logic [31:0] LOCAL_RSP = 32'h0;

    function automatic logic [6:0] funct7_of(input logic [9:0] id);
        return id[9:3];
    endfunction

    function automatic logic [2:0] funct3_of(input logic [9:0] id);
        return id[2:0];
    endfunction
endpackage

// File: rtl/cfu_rsp_fifo.sv
// cfu_rsp_fifo: first-word fall-through response FIFO with occupancy count; a pop in the same
// cycle frees the slot, so push is accepted at full when popping.
module cfu_rsp_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         push,
    input  logic [31:0]                  push_data,
    input  logic                         pop,
    output logic [31:0]                  head,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          wr, rd;

    assign rd   = pop && count != '0;
    assign wr   = push && (count != CW'(DEPTH) || rd);
    assign head = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem    <= '{default: '0};
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (rd) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(wr) - CW'(rd);
        end
    end
endmodule

// File: rtl/cfu_cmd_bridge.sv
// cfu_cmd_bridge: holds one CPU command, pulses it to Cfu under response-credit control and
// returns Cfu (or locally generated) responses to the CPU in order through a FWFT FIFO.
module cfu_cmd_bridge
    import cfu_bridge_pkg::*;
#(
    parameter int RSP_DEPTH   = 4,
    parameter int CFU_LATENCY = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cpu_cmd_valid,
    output logic        cpu_cmd_ready,
    input  logic [9:0]  cpu_cmd_function_id,
    input  logic [31:0] cpu_cmd_inputs_0,
    input  logic [31:0] cpu_cmd_inputs_1,
    output logic        cpu_rsp_valid,
    input  logic        cpu_rsp_ready,
    output logic [31:0] cpu_rsp_outputs_0,
    output logic        cfu_cmd_valid,
    input  logic        cfu_cmd_ready,
    output logic [9:0]  cfu_cmd_function_id,
    output logic [31:0] cfu_cmd_inputs_0,
    output logic [31:0] cfu_cmd_inputs_1,
    input  logic        cfu_rsp_valid,
    output logic        cfu_rsp_ready,
    input  logic [31:0] cfu_rsp_outputs_0,
    output logic        err_unexpected_rsp
);
    localparam int CW = $clog2(RSP_DEPTH + 1);
    localparam int BW = $clog2(CFU_LATENCY + 1);

    logic                   full, blank, tail, issue, local_done, accept, push, pop;
    logic [BW-1:0]          blank_cnt;
    logic [CFU_LATENCY-1:0] inflight;
    logic [CW-1:0]          fifo_cnt;
    int                     inflight_cnt;

    always_comb begin
        inflight_cnt = 0;
        for (int i = 0; i < CFU_LATENCY; i++) inflight_cnt += int'(inflight[i]);
    end

    assign blank = blank_cnt != '0;
    assign tail  = inflight[CFU_LATENCY-1];
    // Responses still owed by Cfu count against the FIFO because Cfu cannot be stalled.
    assign issue = full && funct7_of(cfu_cmd_function_id) == '0 && cfu_cmd_ready
                   && inflight_cnt + int'(fifo_cnt) < RSP_DEPTH;
    assign local_done = full && funct7_of(cfu_cmd_function_id) != '0 && inflight == '0
                        && fifo_cnt != CW'(RSP_DEPTH);
    assign cpu_cmd_ready = !blank && (!full || issue);
    assign accept        = cpu_cmd_valid && cpu_cmd_ready;
    assign cfu_cmd_valid = issue;
    assign push          = (tail && cfu_rsp_valid) || local_done;
    assign pop           = cpu_rsp_valid && cpu_rsp_ready;
    assign cpu_rsp_valid = fifo_cnt != '0;

    cfu_rsp_fifo #(.DEPTH(RSP_DEPTH)) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (local_done ? LOCAL_RSP : cfu_rsp_outputs_0),
        .pop       (pop),
        .head      (cpu_rsp_outputs_0),
        .count     (fifo_cnt)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            full                <= 1'b0;
            cfu_cmd_function_id <= '0;
            cfu_cmd_inputs_0    <= '0;
            cfu_cmd_inputs_1    <= '0;
            blank_cnt           <= BW'(CFU_LATENCY);
            inflight            <= '0;
            cfu_rsp_ready       <= 1'b0;
            err_unexpected_rsp  <= 1'b0;
        end else begin
            if (accept) begin
                full                <= 1'b1;
                cfu_cmd_function_id <= cpu_cmd_function_id;
                cfu_cmd_inputs_0    <= cpu_cmd_inputs_0;
                cfu_cmd_inputs_1    <= cpu_cmd_inputs_1;
            end else if (issue || local_done) begin
                full <= 1'b0;
            end
            if (blank) blank_cnt <= blank_cnt - BW'(1);
            inflight      <= (inflight << 1) | CFU_LATENCY'(issue);
            cfu_rsp_ready <= 1'b1;
            // Stale Cfu pipeline contents drain out while blanking and are ignored.
            if (!blank && cfu_rsp_valid != tail) err_unexpected_rsp <= 1'b1;
        end
    end
endmodule

// File: tb/tb_cfu_cmd_bridge.sv
// tb_cfu_cmd_bridge: pairs the bridge with a behavioural Cfu and checks every CPU response
// against an in-order reference queue, plus timing, backpressure, reset and error cases.
module tb_cfu_cmd_bridge;
    import cfu_bridge_pkg::*;

    localparam int LAT = 3;

    logic        clk = 1'b0, reset_n = 1'b1;
    logic        cpu_cmd_valid, cpu_cmd_ready, cpu_rsp_valid, cpu_rsp_ready;
    logic [9:0]  cpu_cmd_function_id, cfu_cmd_function_id;
    logic [31:0] cpu_cmd_inputs_0, cpu_cmd_inputs_1, cpu_rsp_outputs_0;
    logic        cfu_cmd_valid, cfu_cmd_ready, cfu_rsp_valid, cfu_rsp_ready, err_unexpected_rsp;
    logic [31:0] cfu_cmd_inputs_0, cfu_cmd_inputs_1, cfu_rsp_outputs_0;
    logic        force_rsp = 1'b0, rnd = 1'b0;

    always #5 clk = ~clk;

    cfu_cmd_bridge #(.RSP_DEPTH(4), .CFU_LATENCY(LAT)) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .cpu_cmd_valid       (cpu_cmd_valid),
        .cpu_cmd_ready       (cpu_cmd_ready),
        .cpu_cmd_function_id (cpu_cmd_function_id),
        .cpu_cmd_inputs_0    (cpu_cmd_inputs_0),
        .cpu_cmd_inputs_1    (cpu_cmd_inputs_1),
        .cpu_rsp_valid       (cpu_rsp_valid),
        .cpu_rsp_ready       (cpu_rsp_ready),
        .cpu_rsp_outputs_0   (cpu_rsp_outputs_0),
        .cfu_cmd_valid       (cfu_cmd_valid),
        .cfu_cmd_ready       (cfu_cmd_ready),
        .cfu_cmd_function_id (cfu_cmd_function_id),
        .cfu_cmd_inputs_0    (cfu_cmd_inputs_0),
        .cfu_cmd_inputs_1    (cfu_cmd_inputs_1),
        .cfu_rsp_valid       (cfu_rsp_valid),
        .cfu_rsp_ready       (cfu_rsp_ready),
        .cfu_rsp_outputs_0   (cfu_rsp_outputs_0),
        .err_unexpected_rsp  (err_unexpected_rsp)
    );

    function automatic logic [31:0] calc(input logic [2:0] f3, input logic [31:0] a, b, m);
        logic [31:0] r;
        r = '0;
        case (f3)
            FUNCT3_SUM:   r = a + b;
            FUNCT3_SWAP:  r = {a[7:0], a[15:8], a[23:16], a[31:24]};
            FUNCT3_REV:   for (int i = 0; i < 32; i++) r[i] = a[31-i];
            FUNCT3_STORE: r = 32'hFFFF_FFFF;
            FUNCT3_LOAD:  r = m;
            default:      r = '0;
        endcase
        return r;
    endfunction

    // Cfu stand-in: fixed-latency pipeline with no reset, so it can leak responses after a bridge reset.
    logic [LAT-1:0] cfu_pv = '0;
    logic [31:0]    cfu_pd [LAT];
    logic [31:0]    cfu_mem [16];
    logic [31:0]    ref_mem [16];
    assign cfu_rsp_valid     = cfu_pv[LAT-1] | force_rsp;
    assign cfu_rsp_outputs_0 = cfu_pd[LAT-1];

    always @(posedge clk) begin
        cfu_pv    <= {cfu_pv[LAT-2:0], cfu_cmd_valid & cfu_cmd_ready};
        cfu_pd[0] <= calc(funct3_of(cfu_cmd_function_id), cfu_cmd_inputs_0, cfu_cmd_inputs_1,
                          cfu_mem[cfu_cmd_inputs_0[3:0]]);
        for (int i = 1; i < LAT; i++) cfu_pd[i] <= cfu_pd[i-1];
        if (cfu_cmd_valid && cfu_cmd_ready && funct3_of(cfu_cmd_function_id) == FUNCT3_STORE)
            cfu_mem[cfu_cmd_inputs_0[3:0]] <= cfu_cmd_inputs_1;
    end

    int          cyc = 0, n_checks = 0, n_pass = 0, n_issue = 0, n_cfu_cmds = 0, n_rsp = 0;
    int          issue_cyc[$], rsp_cyc[$];
    logic [31:0] exp_q[$];
    int          n0, r0;
    logic [9:0]  rid;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", tag, got, exp);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: each accepted command owes exactly one response, in acceptance order.
    always @(negedge clk) if (reset_n) begin
        if (cpu_cmd_valid && cpu_cmd_ready) begin
            if (funct7_of(cpu_cmd_function_id) != 7'd0) exp_q.push_back(32'h0);
            else begin
                exp_q.push_back(calc(funct3_of(cpu_cmd_function_id), cpu_cmd_inputs_0,
                                     cpu_cmd_inputs_1, ref_mem[cpu_cmd_inputs_0[3:0]]));
                n_cfu_cmds++;
                if (funct3_of(cpu_cmd_function_id) == FUNCT3_STORE)
                    ref_mem[cpu_cmd_inputs_0[3:0]] = cpu_cmd_inputs_1;
            end
        end
        if (cfu_cmd_valid && cfu_cmd_ready) begin
            n_issue++;
            issue_cyc.push_back(cyc);
            chk("issue_funct7", 32'(funct7_of(cfu_cmd_function_id)), 32'd0);
        end
        if (cpu_rsp_valid && cpu_rsp_ready) begin
            n_rsp++;
            rsp_cyc.push_back(cyc);
            if (exp_q.size() == 0) chk("rsp_extra", exp_q.size(), 1);
            else chk("rsp_data", cpu_rsp_outputs_0, exp_q.pop_front());
        end
    end

    always @(posedge clk) if (rnd) begin
        #1;
        cpu_rsp_ready = $urandom_range(0, 3) != 0;
        cfu_cmd_ready = $urandom_range(0, 4) != 0;
    end

    task automatic send(input logic [9:0] id, input logic [31:0] a, input logic [31:0] b);
        cpu_cmd_valid       = 1'b1;
        cpu_cmd_function_id = id;
        cpu_cmd_inputs_0    = a;
        cpu_cmd_inputs_1    = b;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (cpu_cmd_ready) break;
            if (i == 199) chk("send_timeout", cpu_cmd_ready, 1);
        end
        @(posedge clk);
        #1;
        cpu_cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int i;
        i = 0;
        do begin
            @(posedge clk);
            i++;
        end while (exp_q.size() != 0 && i < 400);
        #1;
        chk("drain_left", exp_q.size(), 0);
        chk("issue_count", n_issue, n_cfu_cmds);
    endtask

    initial begin
        cpu_cmd_valid = 0; cpu_cmd_function_id = 0; cpu_cmd_inputs_0 = 0; cpu_cmd_inputs_1 = 0;
        cpu_rsp_ready = 0; cfu_cmd_ready = 1;
        for (int i = 0; i < 16; i++) begin cfu_mem[i] = 0; ref_mem[i] = 0; end
        for (int i = 0; i < LAT; i++) cfu_pd[i] = 0;
        #1 reset_n = 0;
        #2;
        chk("rst_cmd_ready", cpu_cmd_ready, 0);
        chk("rst_rsp_valid", cpu_rsp_valid, 0);
        chk("rst_rsp_data", cpu_rsp_outputs_0, 0);
        chk("rst_cfu_valid", cfu_cmd_valid, 0);
        chk("rst_cfu_id", 32'(cfu_cmd_function_id), 0);
        chk("rst_cfu_rsp_ready", cfu_rsp_ready, 0);
        chk("rst_err", err_unexpected_rsp, 0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1;
        for (int i = 0; i < LAT; i++) begin @(negedge clk); chk("blank_ready", cpu_cmd_ready, 0); end
        @(negedge clk);
        chk("post_blank_ready", cpu_cmd_ready, 1);
        chk("post_rst_rsp_ready", cfu_rsp_ready, 1);
        @(posedge clk); #1;

        // single command latency
        cpu_rsp_ready = 1;
        send(10'h000, 32'h05, 32'h0A);
        @(negedge clk); chk("s1_issue", cfu_cmd_valid, 1); chk("s1_in0", cfu_cmd_inputs_0, 32'h05);
        @(negedge clk); chk("s1_pulse", cfu_cmd_valid, 0);
        @(negedge clk);
        @(negedge clk); chk("s1_early", cpu_rsp_valid, 0);
        @(negedge clk); chk("s1_valid", cpu_rsp_valid, 1); chk("s1_data", cpu_rsp_outputs_0, 32'h0F);
        @(posedge clk); #1;
        drain();

        // back-to-back swaps
        issue_cyc.delete(); rsp_cyc.delete();
        send(10'h001, 32'h11223344, 0); send(10'h001, 32'h55667788, 0);
        send(10'h001, 32'h99AABBCC, 0); send(10'h001, 32'hDDEEFF00, 0);
        drain();
        chk("s2_n_issue", issue_cyc.size(), 4);
        chk("s2_n_rsp", rsp_cyc.size(), 4);
        chk("s2_issue_span", issue_cyc[3] - issue_cyc[0], 3);
        chk("s2_rsp_span", rsp_cyc[3] - rsp_cyc[0], 3);
        chk("s2_latency", rsp_cyc[0] - issue_cyc[0], 4);

        // credit stall with CPU not taking responses
        cpu_rsp_ready = 0; n0 = n_issue; r0 = n_rsp;
        for (int i = 0; i < 5; i++) send(10'h000, 32'(i * 7), 32'(100 + i));
        cpu_cmd_valid = 1; cpu_cmd_function_id = 10'h002; cpu_cmd_inputs_0 = 32'h0000_00F1;
        repeat (8) @(negedge clk);
        chk("s3_issued", n_issue - n0, 4);
        chk("s3_cmd_ready", cpu_cmd_ready, 0);
        chk("s3_rsp_valid", cpu_rsp_valid, 1);
        chk("s3_rsp_hold", cpu_rsp_outputs_0, exp_q[0]);
        @(posedge clk); #1;
        cpu_rsp_ready = 1;
        send(10'h002, 32'h0000_00F1, 0);
        drain();
        chk("s3_n_rsp", n_rsp - r0, 6);
        chk("s3_err", err_unexpected_rsp, 0);

        // store/load then a locally completed command
        n0 = n_issue;
        send(10'h003, 32'h5, 32'h1234); send(10'h004, 32'h5, 0); send(10'h008, 32'h77, 32'h99);
        drain();
        chk("s4_issued", n_issue - n0, 2);

        // randomized traffic with random backpressure on both sides
        rnd = 1;
        for (int k = 0; k < 80; k++) begin
            rid = {($urandom_range(0, 4) == 0) ? 7'($urandom_range(1, 127)) : 7'd0, 3'($urandom_range(0, 5))};
            send(rid, $urandom, $urandom);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        rnd = 0;
        @(posedge clk); #2;
        cpu_rsp_ready = 1; cfu_cmd_ready = 1;
        drain();
        chk("rnd_err", err_unexpected_rsp, 0);

        // reset during a burst; Cfu leftovers land in the blanking window
        send(10'h001, 32'h01020304, 0); send(10'h001, 32'h05060708, 0); send(10'h001, 32'h090A0B0C, 0);
        #1 reset_n = 0;
        #1;
        chk("s5_cmd_valid", cfu_cmd_valid, 0);
        chk("s5_cmd_ready", cpu_cmd_ready, 0);
        chk("s5_cmd_in0", cfu_cmd_inputs_0, 0);
        chk("s5_cfu_rsp_ready", cfu_rsp_ready, 0);
        exp_q.delete(); n_issue = 0; n_cfu_cmds = 0;
        @(posedge clk); #1 reset_n = 1;
        for (int i = 0; i < LAT; i++) begin
            @(negedge clk);
            chk("s5_blank_ready", cpu_cmd_ready, 0);
            chk("s5_blank_rsp", cpu_rsp_valid, 0);
        end
        @(negedge clk);
        chk("s5_ready", cpu_cmd_ready, 1);
        chk("s5_fifo_empty", cpu_rsp_valid, 0);
        chk("s5_err_blank", err_unexpected_rsp, 0);
        @(posedge clk); #1;
        send(10'h000, 32'h05, 32'h0A);
        drain();
        chk("s5_err", err_unexpected_rsp, 0);

        // spurious Cfu response
        force_rsp = 1;
        @(posedge clk); #1 force_rsp = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("s6_err_sticky", err_unexpected_rsp, 1);
            chk("s6_no_push", cpu_rsp_valid, 0);
        end
        @(posedge clk); #1 reset_n = 0;
        #1;
        chk("s6_err_reset", err_unexpected_rsp, 0);
        @(posedge clk); #1 reset_n = 1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
